// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, CRC constants and monitor state type.
// Used by the scan generator, the frame monitor and pixel generators.
package vga_pkg;

    // 800x600-class timing: 800 active of 1056 total clocks per line,
    // trimmed to 480 active lines of 525 total lines per frame.
    localparam int H_ACTIVE_DEF = 800;
    localparam int H_TOTAL_DEF  = 1056;
    localparam int H_SYNC_DEF   = 128;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL_DEF  = 525;
    localparam int V_SYNC_DEF   = 4;

    // CRC-16-CCITT, MSB-first, no reflection, no final XOR.
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic {
        IDLE,
        MEASURE
    } mon_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc16_ccitt_step.sv
// One 16-bit data word folded into a CRC-16-CCITT, MSB first.
// Ports: crc_in (running CRC), data (word), crc_out (updated CRC).
module crc16_ccitt_step
    import vga_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [15:0] data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Unrolled bit-serial LFSR: one shift per data bit, MSB first.
    always_comb begin
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA monitor: recovers geometry, CRC and a probe pixel.
// Ports: clk/rst, vga_* inputs, probe_x/y; per-frame results + flags.
module vga_frame_monitor
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int H_TOTAL         = H_TOTAL_DEF,
    parameter int V_TOTAL         = V_TOTAL_DEF,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        vga_de,
    input  logic [15:0] vga_rgb,
    input  logic [15:0] probe_x,
    input  logic [15:0] probe_y,
    output logic        frame_done,
    output logic        locked,
    output logic [15:0] meas_h_total,
    output logic [15:0] meas_h_active,
    output logic [15:0] meas_v_total,
    output logic [15:0] meas_v_active,
    output logic [15:0] frame_crc,
    output logic [15:0] probe_color,
    output logic [15:0] frame_count,
    output logic        geom_err,
    output logic        de_err
);

    localparam logic        POL    = (SYNC_ACTIVE_LOW != 0);
    localparam logic [15:0] EXP_HA = 16'(H_ACTIVE);
    localparam logic [15:0] EXP_VA = 16'(V_ACTIVE);
    localparam logic [15:0] EXP_HT = 16'(H_TOTAL);
    localparam logic [15:0] EXP_VT = 16'(V_TOTAL);

    // Input stage (_r) and one-cycle-older copy (_p) for edge detection.
    logic        hs_r, vs_r, de_r;
    logic        hs_p, vs_p, de_p;
    logic [15:0] rgb_r;

    logic hs_edge, vs_edge, de_fall;

    mon_state_t state, state_nxt;
    logic       frame_start, frame_end;

    logic [15:0] hcnt, h_total_w, h_active_w;
    logic [15:0] x, y, vlines, crc, probe_w;
    logic        probe_seen;

    logic [15:0] h_total_n, h_active_n, y_n, vlines_n;
    logic [15:0] crc_step, crc_n, probe_n, x_n;
    logic        probe_hit, probe_seen_n, de_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_r  <= 1'b0;
            vs_r  <= 1'b0;
            de_r  <= 1'b0;
            rgb_r <= '0;
            hs_p  <= 1'b0;
            vs_p  <= 1'b0;
            de_p  <= 1'b0;
        end else begin
            // Normalise so that 1 always means "sync asserted".
            hs_r  <= vga_hsync ^ POL;
            vs_r  <= vga_vsync ^ POL;
            de_r  <= vga_de;
            rgb_r <= vga_rgb;
            hs_p  <= hs_r;
            vs_p  <= vs_r;
            de_p  <= de_r;
        end
    end

    assign hs_edge = hs_r & ~hs_p;
    assign vs_edge = vs_r & ~vs_p;
    assign de_fall = de_p & ~de_r;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (vs_edge) begin
                    state_nxt   = MEASURE;
                    frame_start = 1'b1;
                end
            end
            MEASURE: begin
                if (vs_edge) begin
                    frame_start = 1'b1;
                    frame_end   = 1'b1;
                end
            end
        endcase
    end

    crc16_ccitt_step u_crc (
        .crc_in  (crc),
        .data    (rgb_r),
        .crc_out (crc_step)
    );

    // Next working values including this cycle's events, so a frame
    // closing on the same cycle as a line end or pixel still sees them.
    always_comb begin
        h_total_n    = hs_edge ? hcnt : h_total_w;
        h_active_n   = de_fall ? x : h_active_w;
        y_n          = de_fall ? sat_inc(y) : y;
        vlines_n     = hs_edge ? sat_inc(vlines) : vlines;
        crc_n        = de_r ? crc_step : crc;
        probe_hit    = de_r && (x == probe_x) && (y == probe_y);
        probe_n      = probe_hit ? rgb_r : probe_w;
        probe_seen_n = probe_seen | probe_hit;
        de_bad       = (de_fall && (x != EXP_HA)) || (de_r && vs_r);
        if (hs_edge)   x_n = '0;
        else if (de_r) x_n = sat_inc(x);
        else           x_n = x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt       <= '0;
            h_total_w  <= '0;
            h_active_w <= '0;
            x          <= '0;
            y          <= '0;
            vlines     <= '0;
            crc        <= CRC_INIT;
            probe_w    <= '0;
            probe_seen <= 1'b0;
        end else begin
            hcnt <= hs_edge ? 16'd1 : sat_inc(hcnt);
            if (frame_start) begin
                h_total_w  <= '0;
                h_active_w <= '0;
                x          <= '0;
                y          <= '0;
                vlines     <= '0;
                crc        <= CRC_INIT;
                probe_w    <= '0;
                probe_seen <= 1'b0;
            end else begin
                h_total_w  <= h_total_n;
                h_active_w <= h_active_n;
                x          <= x_n;
                y          <= y_n;
                vlines     <= vlines_n;
                crc        <= crc_n;
                probe_w    <= probe_n;
                probe_seen <= probe_seen_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done    <= 1'b0;
            locked        <= 1'b0;
            meas_h_total  <= '0;
            meas_h_active <= '0;
            meas_v_total  <= '0;
            meas_v_active <= '0;
            frame_crc     <= '0;
            probe_color   <= '0;
            frame_count   <= '0;
            geom_err      <= 1'b0;
            de_err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Partial lines before the first frame edge are not judged.
            if (state == MEASURE && de_bad) de_err <= 1'b1;
            if (frame_end) begin
                frame_done    <= 1'b1;
                locked        <= 1'b1;
                meas_h_total  <= h_total_n;
                meas_h_active <= h_active_n;
                meas_v_total  <= vlines_n;
                meas_v_active <= y_n;
                frame_crc     <= crc_n;
                if (probe_seen_n) probe_color <= probe_n;
                frame_count   <= frame_count + 16'd1;
                geom_err      <= (h_total_n  != EXP_HT) ||
                                 (h_active_n != EXP_HA) ||
                                 (vlines_n   != EXP_VT) ||
                                 (y_n        != EXP_VA);
            end
        end
    end

endmodule
